// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
// Collects a three-beat command (opcode, operand A, operand B) from an
// 8-bit valid/ready stream. It presents the command to the ALU stage
// as registered operands with a valid/ready handshake.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst_n      - synchronous reset, ACTIVE-HIGH despite the _n suffix
//   in_data    - command beat (opcode beat uses [3:0], operands use [7:0])
//   in_valid   - upstream beat valid
//   in_ready   - block accepts a beat this cycle (registered)
//   op_a/op_b  - registered operands to the ALU stage
//   op_code    - registered ALU opcode
//   op_valid   - complete command presented (registered)
//   op_ready   - ALU stage accepts the command
//   abort      - drop any partial or pending command
//   err        - one-cycle pulse when a command times out between beats
//   txn_count  - number of issued commands, wraps at 256
module alu_operand_sequencer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    output logic [3:0] op_code,
    output logic       op_valid,
    input  logic       op_ready,
    input  logic       abort,
    output logic       err,
    output logic [7:0] txn_count
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned CNT_W  = 8;

    // Last idle-counter value before the timeout fires
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GET_A = 2'd1,
        GET_B = 2'd2,
        ISSUE = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    idle_cnt_q;
    logic [CNT_W-1:0]    idle_cnt_d;
    logic [DATA_W-1:0]   op_a_d;
    logic [DATA_W-1:0]   op_b_d;
    logic [CODE_W-1:0]   op_code_d;
    logic [CNT_W-1:0]    txn_count_d;
    logic                err_d;
    logic                in_ready_d;
    logic                op_valid_d;
    logic                beat;
    logic                issue;

    // Handshakes use the registered ready/valid, so there is no combinational
    // path from in_valid/op_ready back to in_ready/op_valid.
    assign beat  = in_valid && in_ready;
    assign issue = op_valid && op_ready;

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        idle_cnt_d  = idle_cnt_q;
        op_a_d      = op_a;
        op_b_d      = op_b;
        op_code_d   = op_code;
        txn_count_d = txn_count;
        err_d       = 1'b0;

        if (abort) begin
            // Abort beats any same-cycle beat or issue.
            state_d    = IDLE;
            idle_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (beat) begin
                        op_code_d  = in_data[CODE_W-1:0];
                        idle_cnt_d = '0;
                        state_d    = GET_A;
                    end
                end
                GET_A, GET_B: begin
                    if (beat) begin
                        if (state_q == GET_A) begin
                            op_a_d  = in_data;
                            state_d = GET_B;
                        end else begin
                            op_b_d  = in_data;
                            state_d = ISSUE;
                        end
                        idle_cnt_d = '0;
                    end else if (idle_cnt_q == IDLE_LAST) begin
                        // This idle cycle brings the count to TIMEOUT.
                        state_d    = IDLE;
                        idle_cnt_d = '0;
                        err_d      = 1'b1;
                    end else begin
                        idle_cnt_d = idle_cnt_q + CNT_W'(1);
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        txn_count_d = txn_count + CNT_W'(1);
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Handshake flags are decoded from the next state and then registered.
        in_ready_d = (state_d != ISSUE);
        op_valid_d = (state_d == ISSUE);
    end

    // State and output registers, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= IDLE;
            idle_cnt_q <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_code    <= '0;
            txn_count  <= '0;
            err        <= 1'b0;
            in_ready   <= 1'b1;
            op_valid   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            op_a       <= op_a_d;
            op_b       <= op_b_d;
            op_code    <= op_code_d;
            txn_count  <= txn_count_d;
            err        <= err_d;
            in_ready   <= in_ready_d;
            op_valid   <= op_valid_d;
        end
    end

endmodule

// File: doc/alu_operand_sequencer.md
ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 15: max idle cycles allowed between beats of one command (range 1..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-high reset, named per codebase convention; sampled on rising clk edge; the _n suffix does not imply low polarity.
REQ-004 in_data  input  8  command beat: opcode beat uses [3:0], [7:4] ignored; operand beats use all 8 bits.
REQ-005 in_valid  input  1  upstream beat valid.
REQ-006 in_ready  output 1  block accepts a beat this cycle.
REQ-007 op_a  output 8  registered operand A to ALU stage.
REQ-008 op_b  output 8  registered operand B to ALU stage.
REQ-009 op_code  output 4  registered ALU opcode.
REQ-010 op_valid  output 1  op_a/op_b/op_code form a complete command.
REQ-011 op_ready  input  1  downstream ALU stage accepts the command.
REQ-012 abort  input  1  discard any partial or pending command.
REQ-013 err  output 1  one-cycle pulse on timeout.
REQ-014 txn_count  output 8  count of commands issued (handshaked).

Function
REQ-015 Beat transfer = in_valid && in_ready in the same cycle; issue = op_valid && op_ready in the same cycle.
REQ-016 FSM states: IDLE, GET_A, GET_B, ISSUE; encoding free.
REQ-017 IDLE: in_ready=1; on beat, op_code <= in_data[3:0], go GET_A.
REQ-018 GET_A: in_ready=1; on beat, op_a <= in_data, go GET_B.
REQ-019 GET_B: in_ready=1; on beat, op_b <= in_data, go ISSUE.
REQ-020 ISSUE: in_ready=0, op_valid=1; op_a/op_b/op_code held stable; on issue, txn_count increments by 1 (wraps 255->0), go IDLE.
REQ-021 op_valid is 0 in every state other than ISSUE; op_valid is a registered (state-decoded) signal, no combinational path from op_ready to op_valid.
REQ-022 in_ready has no combinational dependence on in_valid or op_ready; first beat of the next command is accepted no earlier than the cycle after issue.
REQ-023 Idle counter: cleared on every beat and on entry to GET_A; increments each cycle in GET_A/GET_B without a beat; when it reaches TIMEOUT, next state IDLE and err=1 for exactly one cycle; op_* registers retain last values.
REQ-024 Idle counter does not run in IDLE or ISSUE; ISSUE waits indefinitely for op_ready.
REQ-025 abort (when rst_n=0) forces next state IDLE from any state, clears idle counter, no err pulse, no txn_count change; abort wins over a simultaneous beat or issue in the same cycle (beat not captured, issue not counted).
REQ-026 Minimum command latency: opcode beat in cycle N, A in N+1, B in N+2 -> op_valid=1 in N+3.

Reset
REQ-027 rst_n=1 at a rising edge: state IDLE, op_a=0, op_b=0, op_code=0, op_valid=0, err=0, txn_count=0, idle counter=0; in_ready=1 in the first cycle after reset is released.
REQ-028 rst_n has priority over abort, beats and issue; reset mid-command discards the partial command.

Verification
REQ-029 Back-to-back: beats 0x02, 0x35, 0x0A with in_valid=1, op_ready=1 -> op_valid high exactly one cycle with op_code=2, op_a=0x35, op_b=0x0A; txn_count=1; in_ready=0 that cycle.
REQ-030 Backpressure: same command, op_ready=0 for 5 cycles then 1 -> op_valid held 6 cycles with stable operands, in_ready=0 throughout, single txn_count increment.
REQ-031 Timeout (TIMEOUT=15): opcode beat then no in_valid -> after 15 idle cycles err=1 one cycle, state IDLE, op_valid never asserted, txn_count unchanged.
REQ-032 Abort: opcode 0x7 and A=0x11 accepted, abort=1 with in_valid=1 on B beat -> B not captured, return to IDLE, no err; following full command 0x1,0xFF,0x01 issues with op_code=1.
REQ-033 Wrap: 256 issued commands -> txn_count returns to 0x00.
REQ-034 Reset mid-operation: rst_n=1 while in ISSUE with op_ready=0 -> next cycle op_valid=0, all outputs at REQ-027 values, in_ready=1.
